// File: rtl/seq_detector_n.sv
// Parametrised serial pattern detector with runtime pattern reload, selectable
// overlapping/non-overlapping detection and a saturating match counter.
module seq_detector_n #(
  parameter int             LEN     = 4,
  parameter logic [LEN-1:0] PATTERN = 4'b1010,
  parameter int             CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in,
  input  logic             overlap,
  input  logic             load,
  input  logic [LEN-1:0]   load_pattern,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt,
  output logic [LEN-1:0]   pattern_q
);

  localparam int                FILL_W = $clog2(LEN + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(LEN);

  logic [LEN-1:0]    hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [LEN-1:0]    pattern_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              out_q, out_d;

  logic [LEN-1:0]    hist_shift;
  logic [FILL_W-1:0] fill_next;
  logic              hit;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [FILL_W-1:0] sat_inc_fill(input logic [FILL_W-1:0] v);
    return (v == FILL_FULL) ? v : v + FILL_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q    <= '0;
      fill_q    <= '0;
      pattern_q <= PATTERN;
      cnt_q     <= '0;
      out_q     <= 1'b0;
    end else begin
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      pattern_q <= pattern_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
    end
  end

  // A match needs a full window of valid bits, so stale reset/load zeros never match.
  always_comb begin
    hist_shift = {hist_q[LEN-2:0], in};
    fill_next  = sat_inc_fill(fill_q);
    hit        = (fill_next == FILL_FULL) && (hist_shift == pattern_q);
  end

  always_comb begin
    hist_d    = hist_q;
    fill_d    = fill_q;
    pattern_d = pattern_q;
    cnt_d     = cnt_q;
    out_d     = 1'b0;
    if (load) begin
      pattern_d = load_pattern;
      hist_d    = '0;
      fill_d    = '0;
    end else if (en) begin
      hist_d = hist_shift;
      fill_d = fill_next;
      out_d  = hit;
      if (hit) begin
        cnt_d = sat_inc_cnt(cnt_q);
        // Non-overlapping: the matched bits are consumed and cannot seed the next match.
        if (!overlap) fill_d = '0;
      end
    end
  end

  assign out       = out_q;
  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detector_n.sv
// Bench for seq_detector_n: two instances (default 1010 and LEN=2/CNT_W=2 "11")
// driven by directed steps then random traffic, checked against a bit-queue model.
module tb_seq_detector_n;

  logic clk = 1'b0;
  logic rst_n;

  logic       en1, in1, ov1, ld1;
  logic [3:0] lp1;
  logic       out1;
  logic [7:0] cnt1;
  logic [3:0] pat1;

  logic       en2, in2, ov2, ld2;
  logic [1:0] lp2;
  logic       out2;
  logic [1:0] cnt2;
  logic [1:0] pat2;

  always #5 clk = ~clk;

  seq_detector_n dut1 (
    .clk(clk), .rst_n(rst_n), .en(en1), .in(in1), .overlap(ov1), .load(ld1),
    .load_pattern(lp1), .out(out1), .match_cnt(cnt1), .pattern_q(pat1)
  );

  seq_detector_n #(.LEN(2), .PATTERN(2'b11), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en2), .in(in2), .overlap(ov2), .load(ld2),
    .load_pattern(lp2), .out(out2), .match_cnt(cnt2), .pattern_q(pat2)
  );

  // Reference model: the valid bits seen since the last clear, oldest first.
  bit mq [2][$];
  int mpat [2];
  int mcnt [2];
  int mout [2];
  int mlen [2] = '{4, 2};
  int mmax [2] = '{255, 3};
  int mrst [2] = '{10, 3};

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int id = 0; id < 2; id++) begin
      mq[id].delete();
      mpat[id] = mrst[id];
      mcnt[id] = 0;
      mout[id] = 0;
    end
  endtask

  task automatic model_step(input int id, input bit ld, input bit en, input bit b,
                            input bit ov, input int lp);
    int  v;
    bit  hit;
    if (ld) begin
      mpat[id] = lp;
      mq[id].delete();
      mout[id] = 0;
    end else if (en) begin
      mq[id].push_back(b);
      if (mq[id].size() > mlen[id]) void'(mq[id].pop_front());
      v = 0;
      for (int i = 0; i < mq[id].size(); i++) v = (v << 1) | int'(mq[id][i]);
      hit = (mq[id].size() == mlen[id]) && (v == mpat[id]);
      mout[id] = int'(hit);
      if (hit) begin
        if (mcnt[id] < mmax[id]) mcnt[id]++;
        if (!ov) mq[id].delete();
      end
    end else begin
      mout[id] = 0;
    end
  endtask

  task automatic check_all();
    chk("out1", 32'(out1), 32'(mout[0]));
    chk("cnt1", 32'(cnt1), 32'(mcnt[0]));
    chk("pat1", 32'(pat1), 32'(mpat[0]));
    chk("out2", 32'(out2), 32'(mout[1]));
    chk("cnt2", 32'(cnt2), 32'(mcnt[1]));
    chk("pat2", 32'(pat2), 32'(mpat[1]));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step(0, ld1, en1, in1, ov1, int'(lp1));
    model_step(1, ld2, en2, in2, ov2, int'(lp2));
    check_all();
  endtask

  // Reset lands mid-cycle while clk is high, so no edge helps clear the outputs.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_out1", 32'(out1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic bit1(input bit b);
    ld1 = 1'b0; en1 = 1'b1; in1 = b;
    tick();
  endtask

  task automatic idle1();
    ld1 = 1'b0; en1 = 1'b0;
    tick();
  endtask

  int pulses;
  int cnt2_exp [6] = '{0, 1, 2, 3, 3, 3};
  int out2_exp [6] = '{0, 1, 1, 1, 1, 1};

  initial begin
    rst_n = 1'b1;
    en1 = 0; in1 = 0; ov1 = 1; ld1 = 0; lp1 = '0;
    en2 = 0; in2 = 0; ov2 = 1; ld2 = 0; lp2 = '0;
    async_reset();

    // Overlap, 101010: matches after bits 4 and 6; dut2 sees six 1s in parallel.
    ov1 = 1'b1;
    ov2 = 1'b1; en2 = 1'b1; in2 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bit1(bit'(i % 2 == 0));
      chk("tp1_out", 32'(out1), 32'((i == 3 || i == 5) ? 1 : 0));
      chk("cnt2_seq", 32'(cnt2), 32'(cnt2_exp[i]));
      chk("out2_seq", 32'(out2), 32'(out2_exp[i]));
    end
    en2 = 1'b0;
    chk("tp1_cnt", 32'(cnt1), 32'd2);
    async_reset();

    // Non-overlap, 101010: only the first window matches.
    ov1 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bit1(bit'(i % 2 == 0));
      chk("tp2_out", 32'(out1), 32'((i == 3) ? 1 : 0));
    end
    chk("tp2_cnt", 32'(cnt1), 32'd1);
    async_reset();

    // 1010 with 3-cycle gaps between bits.
    ov1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bit1(bit'(i % 2 == 0));
      chk("tp3_out", 32'(out1), 32'((i == 3) ? 1 : 0));
      if (i < 3) begin
        for (int g = 0; g < 3; g++) begin
          idle1();
          chk("tp3_gap", 32'(out1), 32'd0);
        end
      end
    end
    chk("tp3_cnt", 32'(cnt1), 32'd1);
    async_reset();

    // Load 1111 while en/in are also active, then eight 1s.
    ld1 = 1'b1; lp1 = 4'b1111; en1 = 1'b1; in1 = 1'b1;
    tick();
    chk("tp4_ldout", 32'(out1), 32'd0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      bit1(1'b1);
      chk("tp4_out", 32'(out1), 32'((i >= 3) ? 1 : 0));
      pulses += int'(out1);
    end
    chk("tp4_pulses", 32'(pulses), 32'd5);
    chk("tp4_pat", 32'(pat1), 32'hf);
    async_reset();

    // Reset mid-stream after 1,0,1, then a lone 0 must not complete the old pattern.
    bit1(1'b1); bit1(1'b0); bit1(1'b1);
    async_reset();
    bit1(1'b0);
    chk("tp6_out", 32'(out1), 32'd0);
    chk("tp6_cnt", 32'(cnt1), 32'd0);
    bit1(1'b1); bit1(1'b0); bit1(1'b1); bit1(1'b0);
    chk("tp6_match", 32'(out1), 32'd1);
    chk("tp6_cnt2", 32'(cnt1), 32'd1);

    // Random traffic on both instances.
    for (int i = 0; i < 600; i++) begin
      ld1 = ($urandom_range(0, 39) == 0);
      lp1 = 4'($urandom);
      en1 = ($urandom_range(0, 9) < 7);
      in1 = 1'($urandom);
      ov1 = ($urandom_range(0, 9) < 6);
      ld2 = ($urandom_range(0, 39) == 0);
      lp2 = 2'($urandom);
      en2 = ($urandom_range(0, 9) < 7);
      in2 = 1'($urandom);
      ov2 = ($urandom_range(0, 9) < 6);
      tick();
      if (i == 300) async_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
